// File: rtl/cpu_controller.sv
// cpu_controller
//   Sequencing controller for a small 16-bit datapath. Accepts one instruction
//   per visit to WAIT, captures opcode/op at acceptance and then steps through
//   operand fetch, ALU execute and register write-back. Every output is a
//   registered Moore output, decoded from the state being entered.
//
// Ports
//   clk     in   single clock, rising edge
//   reset   in   synchronous, active-high reset
//   start   in   execute the instruction on opcode/op (sampled only in WAIT)
//   opcode  in   [2:0] instruction class (110 MOV, 101 ALU)
//   op      in   [1:0] sub-op (MOV: 10 imm, 00 reg; ALU: ADD/CMP/AND/MVN)
//   w       out  idle/ready
//   loada, loadb, loadc, loads  out  load enables for A, B, C and status
//   asel    out  force ALU operand A to zero
//   bsel    out  operand B from sximm5 (never used here)
//   vsel    out  [1:0] write-back source (00 C, 01 sximm8)
//   nsel    out  [2:0] one-hot register select (100 Rn, 010 Rd, 001 Rm)
//   write   out  register-file write enable
//   alu_op  out  [1:0] ALU operation
//   bad_op  out  sticky: last accepted instruction was illegal
//
// state    | meaning
// ---------+--------------------------------------------------
// S_WAIT   | idle, w=1, accepts start
// S_DECODE | classify captured instruction
// S_GET_A  | load A from Rn
// S_GET_B  | load B from Rm
// S_EXEC   | ALU operation; C or status loaded
// S_WR_REG | write C to Rd
// S_WR_IMM | write sximm8 to Rn

module cpu_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic [2:0] nsel,
  output logic       write,
  output logic [1:0] alu_op,
  output logic       bad_op
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WR_REG, S_WR_IMM
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  state_t     state, state_nxt;
  logic [2:0] opc_q, opc_nxt;
  logic [1:0] op_q, op_nxt;
  logic       bad_nxt;

  logic       w_nxt, loada_nxt, loadb_nxt, loadc_nxt, loads_nxt, asel_nxt, write_nxt;
  logic [1:0] vsel_nxt, alu_op_nxt;
  logic [2:0] nsel_nxt;

  logic is_mov, is_alu, nxt_is_alu;

  assign is_mov     = (opc_q == OPC_MOV);
  assign is_alu     = (opc_q == OPC_ALU);
  assign nxt_is_alu = (opc_nxt == OPC_ALU);

  // operand B never comes from sximm5 in this instruction subset
  assign bsel = 1'b0;

  always_comb begin
    state_nxt = state;
    opc_nxt   = opc_q;
    op_nxt    = op_q;
    bad_nxt   = bad_op;

    case (state)
      S_WAIT: begin
        if (start) begin
          opc_nxt   = opcode;
          op_nxt    = op;
          bad_nxt   = 1'b0;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_mov && op_q == 2'b10)
          state_nxt = S_WR_IMM;
        else if ((is_mov && op_q == 2'b00) || (is_alu && op_q == 2'b11))
          state_nxt = S_GET_B;
        else if (is_alu)
          state_nxt = S_GET_A;
        else begin
          state_nxt = S_WAIT;
          bad_nxt   = 1'b1;
        end
      end
      S_GET_A:  state_nxt = S_GET_B;
      S_GET_B:  state_nxt = S_EXEC;
      S_EXEC:   state_nxt = (is_alu && op_q == 2'b01) ? S_WAIT : S_WR_REG;
      S_WR_REG: state_nxt = S_WAIT;
      S_WR_IMM: state_nxt = S_WAIT;
      default:  state_nxt = S_WAIT;
    endcase

    // decode for the state being entered, so the outputs land registered
    w_nxt      = 1'b0;
    loada_nxt  = 1'b0;
    loadb_nxt  = 1'b0;
    loadc_nxt  = 1'b0;
    loads_nxt  = 1'b0;
    asel_nxt   = 1'b0;
    write_nxt  = 1'b0;
    vsel_nxt   = 2'b00;
    nsel_nxt   = 3'b000;
    alu_op_nxt = 2'b00;

    case (state_nxt)
      S_WAIT:  w_nxt = 1'b1;
      S_GET_A: begin
        nsel_nxt  = 3'b100;
        loada_nxt = 1'b1;
      end
      S_GET_B: begin
        nsel_nxt  = 3'b001;
        loadb_nxt = 1'b1;
      end
      S_EXEC: begin
        // MOV reg goes through the ALU as 0 + B
        alu_op_nxt = nxt_is_alu ? op_nxt : 2'b00;
        asel_nxt   = (opc_nxt == OPC_MOV);
        if (nxt_is_alu && op_nxt == 2'b01)
          loads_nxt = 1'b1;
        else
          loadc_nxt = 1'b1;
      end
      S_WR_REG: begin
        nsel_nxt  = 3'b010;
        write_nxt = 1'b1;
      end
      S_WR_IMM: begin
        nsel_nxt  = 3'b100;
        vsel_nxt  = 2'b01;
        write_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_WAIT;
      opc_q  <= 3'b000;
      op_q   <= 2'b00;
      bad_op <= 1'b0;
      w      <= 1'b1;
      loada  <= 1'b0;
      loadb  <= 1'b0;
      loadc  <= 1'b0;
      loads  <= 1'b0;
      asel   <= 1'b0;
      write  <= 1'b0;
      vsel   <= 2'b00;
      nsel   <= 3'b000;
      alu_op <= 2'b00;
    end else begin
      state  <= state_nxt;
      opc_q  <= opc_nxt;
      op_q   <= op_nxt;
      bad_op <= bad_nxt;
      w      <= w_nxt;
      loada  <= loada_nxt;
      loadb  <= loadb_nxt;
      loadc  <= loadc_nxt;
      loads  <= loads_nxt;
      asel   <= asel_nxt;
      write  <= write_nxt;
      vsel   <= vsel_nxt;
      nsel   <= nsel_nxt;
      alu_op <= alu_op_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller. All outputs are packed into one vector
// {w,loada,loadb,loadc,loads,asel,bsel,vsel,nsel,write,alu_op,bad_op} and
// compared one step (rising edge + 1) at a time against hand-built values.

module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w, loada, loadb, loadc, loads, asel, bsel, write, bad_op;
  logic [1:0] vsel, alu_op;
  logic [2:0] nsel;

  int vectors = 0;
  int miscompares = 0;

  cpu_controller dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .op(op),
    .w(w), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .nsel(nsel), .write(write),
    .alu_op(alu_op), .bad_op(bad_op)
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {w, loada, loadb, loadc, loads, asel, bsel, vsel, nsel, write, alu_op, bad_op};

  function automatic logic [15:0] ev(input logic ew, input logic la, input logic lb,
                                     input logic lc, input logic ls, input logic as,
                                     input logic [1:0] vs, input logic [2:0] ns,
                                     input logic wr, input logic [1:0] ao, input logic bd);
    return {ew, la, lb, lc, ls, as, 1'b0, vs, ns, wr, ao, bd};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] oc, input logic [1:0] o);
    opcode = oc;
    op     = o;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  // common expected vectors
  logic [15:0] e_idle, e_idle_bad, e_zero, e_get_a, e_get_b, e_wr_reg, e_wr_imm;

  initial begin
    e_idle     = ev(1,0,0,0,0,0,2'b00,3'b000,0,2'b00,0);
    e_idle_bad = ev(1,0,0,0,0,0,2'b00,3'b000,0,2'b00,1);
    e_zero     = ev(0,0,0,0,0,0,2'b00,3'b000,0,2'b00,0);
    e_get_a    = ev(0,1,0,0,0,0,2'b00,3'b100,0,2'b00,0);
    e_get_b    = ev(0,0,1,0,0,0,2'b00,3'b001,0,2'b00,0);
    e_wr_reg   = ev(0,0,0,0,0,0,2'b00,3'b010,1,2'b00,0);
    e_wr_imm   = ev(0,0,0,0,0,0,2'b01,3'b100,1,2'b00,0);

    reset = 1'b1; start = 1'b0; opcode = 3'b000; op = 2'b00;
    step(); step();
    chk("reset_state", e_idle);
    reset = 1'b0;
    step();
    chk("idle_no_start", e_idle);

    // MOV imm: 3 edges
    issue(3'b110, 2'b10);
    chk("movi_decode", e_zero);
    step(); chk("movi_wr_imm", e_wr_imm);
    step(); chk("movi_done", e_idle);

    // ADD: 6 edges
    issue(3'b101, 2'b00);
    chk("add_decode", e_zero);
    step(); chk("add_get_a", e_get_a);
    step(); chk("add_get_b", e_get_b);
    step(); chk("add_exec", ev(0,0,0,1,0,0,2'b00,3'b000,0,2'b00,0));
    step(); chk("add_wr_reg", e_wr_reg);
    step(); chk("add_done", e_idle);

    // CMP: 5 edges, status load, no write
    issue(3'b101, 2'b01);
    chk("cmp_decode", e_zero);
    step(); chk("cmp_get_a", e_get_a);
    step(); chk("cmp_get_b", e_get_b);
    step(); chk("cmp_exec", ev(0,0,0,0,1,0,2'b00,3'b000,0,2'b01,0));
    step(); chk("cmp_done", e_idle);

    // MOV reg: skips GET_A, asel=1
    issue(3'b110, 2'b00);
    chk("movr_decode", e_zero);
    step(); chk("movr_get_b", e_get_b);
    step(); chk("movr_exec", ev(0,0,0,1,0,1,2'b00,3'b000,0,2'b00,0));
    step(); chk("movr_wr_reg", e_wr_reg);
    step(); chk("movr_done", e_idle);

    // MVN
    issue(3'b101, 2'b11);
    chk("mvn_decode", e_zero);
    step(); chk("mvn_get_b", e_get_b);
    step(); chk("mvn_exec", ev(0,0,0,1,0,0,2'b00,3'b000,0,2'b11,0));
    step(); chk("mvn_wr_reg", e_wr_reg);
    step(); chk("mvn_done", e_idle);

    // illegal: 2 edges, sticky bad_op
    issue(3'b000, 2'b00);
    chk("ill_decode", e_zero);
    step(); chk("ill_done", e_idle_bad);
    step(); chk("ill_sticky", e_idle_bad);
    // illegal sub-op of MOV class
    issue(3'b110, 2'b01);
    chk("ill2_decode", e_zero);
    step(); chk("ill2_done", e_idle_bad);
    // next legal start clears bad_op
    issue(3'b110, 2'b10);
    chk("clr_bad_decode", e_zero);
    step(); chk("clr_bad_wr_imm", e_wr_imm);
    step(); chk("clr_bad_done", e_idle);

    // reset during GET_B of an ADD
    issue(3'b101, 2'b00);
    step(); chk("rst_add_get_a", e_get_a);
    step(); chk("rst_add_get_b", e_get_b);
    reset = 1'b1;
    step(); chk("rst_mid_flight", e_idle);
    reset = 1'b0;
    step(); chk("rst_no_write_1", e_idle);
    step(); chk("rst_no_write_2", e_idle);

    // reset beats start in the same cycle
    reset = 1'b1; opcode = 3'b110; op = 2'b10; start = 1'b1;
    step(); chk("rst_over_start", e_idle);
    reset = 1'b0; start = 1'b0;
    step(); chk("rst_over_start_idle", e_idle);

    // AND with opcode/op disturbed during EXEC
    issue(3'b101, 2'b10);
    step(); chk("and_get_a", e_get_a);
    step(); chk("and_get_b", e_get_b);
    opcode = 3'b000; op = 2'b01; start = 1'b1;
    step(); chk("and_exec", ev(0,0,0,1,0,0,2'b00,3'b000,0,2'b10,0));
    opcode = 3'b110; op = 2'b11;
    step(); chk("and_wr_reg", e_wr_reg);
    start = 1'b0;
    step(); chk("and_done", e_idle);

    // start held high: back-to-back MOV imm
    opcode = 3'b110; op = 2'b10; start = 1'b1;
    step(); chk("b2b_decode_1", e_zero);
    step(); chk("b2b_wr_imm_1", e_wr_imm);
    step(); chk("b2b_wait", e_idle);
    step(); chk("b2b_decode_2", e_zero);
    step(); chk("b2b_wr_imm_2", e_wr_imm);
    start = 1'b0;
    step(); chk("b2b_done", e_idle);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to execute the instruction currently on opcode/op.
REQ-005 opcode  input  3  instruction class: 3'b110 = MOV, 3'b101 = ALU.
REQ-006 op  input  2  sub-op. For MOV: 2'b10 = imm, 2'b00 = reg. For ALU: 00 = ADD, 01 = CMP, 10 = AND, 11 = MVN.
REQ-007 w  output  1  idle/ready, high only in WAIT.
REQ-008 loada, loadb, loadc, loads  output  1 each  load enables for regs A, B, C and status.
REQ-009 asel  output  1  1 = force ALU operand A to 16'd0.
REQ-010 bsel  output  1  1 = operand B from sximm5; always 0 in this block.
REQ-011 vsel  output  2  write-back source: 00 = ALU result C, 01 = sximm8; 1x never driven.
REQ-012 nsel  output  3  one-hot register select: 100 = Rn, 010 = Rd, 001 = Rm, 000 = none.
REQ-013 write  output  1  register-file write enable.
REQ-014 alu_op  output  2  operation code for the 16-bit ALU (00 ADD, 01 SUB, 10 AND, 11 NOT B).
REQ-015 bad_op  output  1  sticky flag: last accepted instruction was illegal.

Function
REQ-016 Outputs SHALL be Moore, decoded from state and captured fields only.
- Any output not listed for a state is 0.
REQ-017 States: WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM.
REQ-018 WAIT: w=1.
- start=1: capture opcode/op into internal regs, clear bad_op, go to DECODE.
- Otherwise stay in WAIT.
REQ-019 start SHALL be ignored in every state except WAIT.
- opcode/op changes after capture SHALL NOT affect the instruction in flight.
REQ-020 DECODE transitions:
- MOV imm -> WR_IMM.
- MOV reg or MVN -> GET_B.
- ADD, CMP or AND -> GET_A.
- Any other {opcode, op} -> WAIT, with bad_op set to 1.
REQ-021 GET_A: nsel=100, loada=1 -> GET_B.
REQ-022 GET_B: nsel=001, loadb=1 -> EXEC.
REQ-023 EXEC: bsel=0.
- alu_op = captured op for ALU class; 2'b00 for MOV reg.
- asel=1 for MOV reg, else 0.
- CMP: loads=1, loadc=0, next state WAIT.
- All others: loadc=1, loads=0, next state WR_REG.
REQ-024 WR_REG: nsel=010, vsel=00, write=1 -> WAIT.
REQ-025 WR_IMM: nsel=100, vsel=01, write=1 -> WAIT.
REQ-026 Latency from the edge sampling start to w=1 (rising edges):
- MOV imm: 3.
- MOV reg, MVN, CMP: 5.
- ADD, AND: 6.
- Illegal: 2.
REQ-027 write SHALL be asserted for exactly one cycle per legal non-CMP instruction.
- write SHALL never be asserted for CMP or illegal instructions.
REQ-028 At most one of loada/loadb/loadc/loads/write SHALL be high in any cycle.
- nsel SHALL be one-hot or zero.
REQ-029 start held high continuously SHALL cause back-to-back instructions, one accepted per visit to WAIT.

Reset
REQ-030 reset=1 at a rising edge SHALL force state WAIT and clear the captured fields and bad_op, regardless of current state.
- Next cycle: w=1, all other outputs 0, nsel=000, vsel=00, alu_op=00.
REQ-031 reset SHALL take priority over start in the same cycle.
- An instruction interrupted mid-sequence by reset SHALL NOT produce write or loads afterwards.

Verification
REQ-032 MOV imm: opcode=110, op=10, start pulse in WAIT.
- DECODE, then WR_IMM with nsel=100, vsel=01, write=1.
- w=1 on the 3rd edge.
REQ-033 ADD: opcode=101, op=00.
- Sequence loada (nsel=100), loadb (nsel=001), loadc with alu_op=00 and asel=0, then write with nsel=010 and vsel=00.
- w=1 on the 6th edge.
REQ-034 CMP: opcode=101, op=01.
- EXEC shows loads=1, loadc=0, alu_op=01.
- No write occurs; w=1 on the 5th edge.
REQ-035 MOV reg, then MVN:
- MOV reg: GET_A skipped; EXEC shows asel=1, alu_op=00.
- MVN: EXEC shows asel=0, alu_op=11.
- Both reach w=1 on the 5th edge.
REQ-036 Illegal opcode=000 -> bad_op=1, w=1 after 2 edges, no load or write strobes.
- The next legal start clears bad_op.
REQ-037 Robustness:
- reset asserted during GET_B of an ADD -> WAIT next cycle with no write.
- opcode changed during EXEC of an AND -> the AND still completes with alu_op=10.
